nor_sweep_ctrl: RTL
===================

Name: nor_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the team's 4-input NOR-only logic function blocks in hardware, replacing the hand-written 16-line testbench stimulus. On a start pulse it drives every input combination in ascending order onto vec_out, which connects to A,B,C,D of the external function block. It waits a programmable settle time, samples the block's F onto f_in, and builds the captured truth table. It then compares the table with an expected table latched at start and reports pass/fail, mismatch count and first failing index.

Parameters:
N_VARS, 4, number of function inputs; table width TW = 2**N_VARS; vec_out bit N_VARS-1 = A (MSB) ... bit 0 = D.
SETTLE_CYCLES, 1, cycles vec_out is held before sampling; legal range 1..255.

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
exp_table  in  TW  expected truth table, bit i = F for vec i; latched on accepted start
f_in  in  1  F output of the function block under control
vec_out  out  N_VARS  input combination driven to the function block
busy  out  1  high from the cycle after start acceptance until DONE is left
done  out  1  one-cycle pulse when results are valid
table_out  out  TW  captured truth table
err_cnt  out  N_VARS+1  number of mismatching entries
fail_idx  out  N_VARS  index of first mismatch; 0 if none
pass  out  1  1 when err_cnt==0; valid from done, held until next start

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; vec_out=0, busy=0, done=0, table_out=0, err_cnt=0, fail_idx=0, pass=0, settle counter=0. Reset takes effect from any state, including mid-sweep, with no partial results retained.
- States are IDLE, SETTLE, SAMPLE and DONE.
- IDLE: if start=1 at edge t, latch exp_table and clear table_out, err_cnt, fail_idx and pass. Set vec_out=0 and go to SETTLE. busy=1 from t+1.
- SETTLE: hold vec_out for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (one cycle):
  - table_out[vec_out] <= f_in.
  - If f_in != exp[vec_out]: err_cnt+1, and on the first mismatch fail_idx <= vec_out.
  - If vec_out == TW-1, go to DONE. Otherwise vec_out+1 and go to SETTLE.
- DONE (one cycle): done=1; pass <= (final err_cnt==0), with the SAMPLE-cycle update included; go to IDLE with busy=0 on the next cycle.
- Vector k occupies cycles t+1+k(S+1) .. t+(k+1)(S+1), where S=SETTLE_CYCLES. done is high in cycle t+TW(S+1)+1. For defaults this is t+33.
- Outputs table_out, err_cnt, fail_idx, pass and vec_out hold their values in IDLE until the next accepted start.
- start while busy or in DONE: ignored, no effect on the sweep.
- start and rst_n=0 in the same cycle: reset wins.
- err_cnt saturates naturally at TW because its width is N_VARS+1; no wrap.
- f_in is sampled only in SAMPLE; glitches elsewhere are ignored.

Optional Feature:
Macro: NOR_SWEEP_STOP_ON_FAIL_EN.
- Defined: on the first mismatch in SAMPLE, go directly to DONE after recording fail_idx. err_cnt=1, pass=0, and table bits for unsampled vectors stay 0. done arrives in cycle t+(fail_idx+1)(S+1)+1.
- Undefined: the sweep always covers all TW vectors. err_cnt counts all mismatches, and fail_idx still reports the first one.

Test Plan:
1. Defaults, correct function block (true table 16'h1894: ones at 2,4,7,11,12), exp_table=16'h1894, start at t -> done only at t+33; table_out=16'h1894, err_cnt=0, fail_idx=0, pass=1; vec_out walks 0..15, each value held 2 cycles.
2. exp_table=16'h1895 -> err_cnt=1, fail_idx=0, pass=0, table_out=16'h1894, done at t+33.
3. SETTLE_CYCLES=3, exp=16'h1894 -> each vec_out held 4 cycles; done at t+65; pass=1.
4. start pulsed again at t+10 and at t+33 (DONE) -> both ignored; single done at t+33; busy low at t+34.
5. rst_n=0 for one edge while vec_out=7 -> next cycle: state IDLE, all outputs 0, no done. A following start gives a clean full sweep with pass=1.
6. NOR_SWEEP_STOP_ON_FAIL_EN defined, exp=16'h1094 (bit 11 cleared) -> done at t+25; fail_idx=11, err_cnt=1, pass=0, table_out=16'h0894. With the macro undefined: done at t+33, table_out=16'h1894, err_cnt=1.

Source files
------------

// File: rtl/nor_sweep_ctrl.sv
// Exhaustive stimulus sequencer for a 4-input NOR-built function block: walks every input vector,
// captures F after a settle delay and scores it against a table. Optional: NOR_SWEEP_STOP_ON_FAIL_EN.
module nor_sweep_ctrl #(
  parameter int unsigned N_VARS        = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2**N_VARS-1:0]  exp_table,
  input  logic                  f_in,
  output logic [N_VARS-1:0]     vec_out,
  output logic                  busy,
  output logic                  done,
  output logic [2**N_VARS-1:0]  table_out,
  output logic [N_VARS:0]       err_cnt,
  output logic [N_VARS-1:0]     fail_idx,
  output logic                  pass
);

  localparam int unsigned TW = 2**N_VARS;
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_VARS-1:0] VecLast = {N_VARS{1'b1}};

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_VARS-1:0] vec_q, vec_d;
  logic [TW-1:0]     exp_q, exp_d;
  logic [TW-1:0]     tbl_q, tbl_d;
  logic [N_VARS:0]   err_q, err_d;
  logic [N_VARS-1:0] fidx_q, fidx_d;
  logic              pass_q, pass_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mismatch;
  logic              last_sample;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    exp_d       = exp_q;
    tbl_d       = tbl_q;
    err_d       = err_q;
    fidx_d      = fidx_q;
    pass_d      = pass_q;
    cnt_d       = cnt_q;
    mismatch    = (f_in != exp_q[vec_q]);
`ifdef NOR_SWEEP_STOP_ON_FAIL_EN
    last_sample = mismatch || (vec_q == VecLast);
`else
    last_sample = (vec_q == VecLast);
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          exp_d   = exp_table;
          tbl_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        tbl_d[vec_q] = f_in;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) fidx_d = vec_q;
        end
        if (last_sample) begin
          // Resolve pass here so it is already valid while done is high.
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = StSettle;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vec_out   = vec_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign table_out = tbl_q;
  assign err_cnt   = err_q;
  assign fail_idx  = fidx_q;
  assign pass      = pass_q;

endmodule
